instruction_sequencer: RTL

- Consumer end of the program-ROM interface. Drives the instruction address and decodes the 28-bit instruction word the ROM returns combinationally.
- Executes NOP delays, STO, ADD, LED, BLE and JMP against an external 8-entry register file.
- Sits between the program ROM and the register file / LED port of the MiniAlu top level.

---
 rtl/instruction_sequencer_pkg.sv | 76 +++++++
 rtl/instruction_sequencer_if.sv | 41 ++++
 rtl/instruction_sequencer_delay_counter.sv | 26 ++
 rtl/instruction_sequencer.sv | 114 +++++++++++
 4 files changed

// File: rtl/instruction_sequencer_pkg.sv
// Shared definitions for the instruction sequencer: widths, opcodes, register
// names, instruction field positions, FSM states and field-extraction helpers.
package instruction_sequencer_pkg;

    localparam int ADDR_W  = 16;
    localparam int DATA_W  = 16;
    localparam int INSTR_W = 28;
    localparam int DELAY_W = 24;
    localparam int REG_W   = 8;
    localparam int LED_W   = 8;

    localparam logic [3:0] OP_NOP = 4'd0;
    localparam logic [3:0] OP_LED = 4'd1;
    localparam logic [3:0] OP_BLE = 4'd2;
    localparam logic [3:0] OP_STO = 4'd3;
    localparam logic [3:0] OP_ADD = 4'd4;
    localparam logic [3:0] OP_JMP = 4'd5;

    localparam logic [REG_W-1:0] R0 = 8'd0;
    localparam logic [REG_W-1:0] R1 = 8'd1;
    localparam logic [REG_W-1:0] R2 = 8'd2;
    localparam logic [REG_W-1:0] R3 = 8'd3;
    localparam logic [REG_W-1:0] R4 = 8'd4;
    localparam logic [REG_W-1:0] R5 = 8'd5;
    localparam logic [REG_W-1:0] R6 = 8'd6;
    localparam logic [REG_W-1:0] R7 = 8'd7;

    localparam int OP_HI   = 27;
    localparam int OP_LO   = 24;
    localparam int DST_HI  = 23;
    localparam int DST_LO  = 16;
    localparam int SRC1_HI = 15;
    localparam int SRC1_LO = 8;
    localparam int SRC0_HI = 7;
    localparam int SRC0_LO = 0;
    localparam int IMM_HI  = 15;
    localparam int IMM_LO  = 0;
    localparam int CNT_HI  = 23;
    localparam int CNT_LO  = 0;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_DELAY = 1'b1
    } state_t;

    typedef struct packed {
        logic [3:0]       opcode;
        logic [REG_W-1:0] dst;
        logic [REG_W-1:0] src1;
        logic [REG_W-1:0] src0;
    } instr_t;

    typedef struct packed {
        state_t             state;
        logic [DELAY_W-1:0] counter;
        logic [ADDR_W-1:0]  pc;
    } debug_t;

    function automatic instr_t decode(input logic [INSTR_W-1:0] word);
        instr_t d;
        d.opcode = word[OP_HI:OP_LO];
        d.dst    = word[DST_HI:DST_LO];
        d.src1   = word[SRC1_HI:SRC1_LO];
        d.src0   = word[SRC0_HI:SRC0_LO];
        return d;
    endfunction

    function automatic logic [DATA_W-1:0] imm16(input logic [INSTR_W-1:0] word);
        return word[IMM_HI:IMM_LO];
    endfunction

    function automatic logic [DELAY_W-1:0] nop_count(input logic [INSTR_W-1:0] word);
        return word[CNT_HI:CNT_LO];
    endfunction

endpackage

// File: rtl/instruction_sequencer_if.sv
// Program-ROM and register-file bus seen by the sequencer. Everything on it is
// combinational within a cycle; there is no valid/ready, the sequencer's hold
// input is the only flow control and it simply freezes all state.
interface instruction_sequencer_if;
    import instruction_sequencer_pkg::*;

    logic [ADDR_W-1:0]  instruction_address;
    logic [INSTR_W-1:0] instruction;
    logic [REG_W-1:0]   read_address0;
    logic [REG_W-1:0]   read_address1;
    logic [DATA_W-1:0]  read_data0;
    logic [DATA_W-1:0]  read_data1;
    logic               write_enable;
    logic [REG_W-1:0]   write_address;
    logic [DATA_W-1:0]  write_data;

    modport master (
        output instruction_address,
        output read_address0,
        output read_address1,
        output write_enable,
        output write_address,
        output write_data,
        input  instruction,
        input  read_data0,
        input  read_data1
    );

    modport slave (
        input  instruction_address,
        input  read_address0,
        input  read_address1,
        input  write_enable,
        input  write_address,
        input  write_data,
        output instruction,
        output read_data0,
        output read_data1
    );

endinterface

// File: rtl/instruction_sequencer_delay_counter.sv
// Loadable down-counter timing NOP delays; done flags the last delay cycle.
module sequencer_delay_counter
    import instruction_sequencer_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               enable,
    input  logic [DELAY_W-1:0] load_value,
    output logic [DELAY_W-1:0] count,
    output logic               done
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (enable && (count != '0)) begin
            count <= count - DELAY_W'(1);
        end
    end

    assign done = (count == DELAY_W'(1));

endmodule

// File: rtl/instruction_sequencer.sv
// Fetch/execute sequencer: drives the PC to the ROM, decodes the returned word
// and executes NOP delays, STO, ADD, LED, BLE and JMP against the register file.
module instruction_sequencer
    import instruction_sequencer_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   hold,
    instruction_sequencer_if.master bus,
    output logic [LED_W-1:0]       led,
    output logic                   busy,
    output debug_t                 debug
);

    state_t             state;
    logic [ADDR_W-1:0]  pc;
    logic [ADDR_W-1:0]  pc_next_seq;
    logic [ADDR_W-1:0]  target;
    instr_t             ins;
    logic [DELAY_W-1:0] count_field;
    logic [DELAY_W-1:0] load_value;
    logic [DELAY_W-1:0] counter;
    logic               counter_done;
    logic               counter_load;
    logic               counter_enable;
    logic               executing;
    logic               long_nop;
    logic               ble_taken;

    assign ins         = decode(bus.instruction);
    assign count_field = nop_count(bus.instruction);
    assign load_value  = count_field - DELAY_W'(1);
    assign pc_next_seq = pc + ADDR_W'(1);
    assign target      = {{(ADDR_W-REG_W){1'b0}}, ins.dst};
    assign ble_taken   = (bus.read_data1 <= bus.read_data0);

    // An instruction only takes effect in RUN on an un-held, un-reset edge.
    assign executing      = !rst && !hold && (state == ST_RUN);
    assign long_nop       = (ins.opcode == OP_NOP) && (count_field > DELAY_W'(1));
    assign counter_load   = executing && long_nop;
    assign counter_enable = !hold && (state == ST_DELAY);

    sequencer_delay_counter u_delay (
        .clk        (clk),
        .rst        (rst),
        .load       (counter_load),
        .enable     (counter_enable),
        .load_value (load_value),
        .count      (counter),
        .done       (counter_done)
    );

    assign bus.instruction_address = pc;
    assign bus.read_address0       = ins.src0;
    assign bus.read_address1       = ins.src1;
    assign bus.write_address       = ins.dst;

    always_comb begin
        bus.write_enable = 1'b0;
        bus.write_data   = bus.read_data1 + bus.read_data0;
        if (ins.opcode == OP_STO) begin
            bus.write_data = imm16(bus.instruction);
        end
        if (executing && ((ins.opcode == OP_STO) || (ins.opcode == OP_ADD))) begin
            bus.write_enable = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_RUN;
            pc    <= '0;
            led   <= '0;
            busy  <= 1'b0;
        end else if (!hold) begin
            case (state)
                ST_RUN: begin
                    case (ins.opcode)
                        OP_NOP: begin
                            if (long_nop) begin
                                state <= ST_DELAY;
                                busy  <= 1'b1;
                            end else begin
                                pc <= pc_next_seq;
                            end
                        end
                        OP_LED: begin
                            led <= bus.read_data1[LED_W-1:0];
                            pc  <= pc_next_seq;
                        end
                        OP_BLE: pc <= ble_taken ? target : pc_next_seq;
                        OP_JMP: pc <= target;
                        // STO, ADD and undefined opcodes all just advance.
                        default: pc <= pc_next_seq;
                    endcase
                end
                ST_DELAY: begin
                    if (counter_done) begin
                        state <= ST_RUN;
                        busy  <= 1'b0;
                        pc    <= pc_next_seq;
                    end
                end
                default: begin
                    state <= ST_RUN;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign debug = '{state: state, counter: counter, pc: pc};

endmodule
